// File: rtl/rbus_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rbus_arb2
// Purpose  : Packet-granular arbiter that merges two rbus FIFO outputs
//            (first-word-fall-through, stb/sof/data/ack) into one rbus stream.
//            A packet is granted only when the downstream FIFO reports room
//            for its whole length. Once granted, the packet streams out
//            without interleaving.
// Options  : RBUS_ARB2_FIXED_PRIO_EN - when defined, source A always wins a
//            tie and the round-robin pointer is removed. When undefined
//            (default), ties are broken round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module rbus_arb2 #(
  parameter int SHORT_LEN = 2,
  parameter int LONG_LEN  = 9,
  parameter int LEN_BIT   = 71
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_stb,
  input  logic        a_sof,
  input  logic [71:0] a_data,
  output logic        a_ack,
  input  logic        b_stb,
  input  logic        b_sof,
  input  logic [71:0] b_data,
  output logic        b_ack,
  output logic        o_stb,
  output logic        o_sof,
  output logic [71:0] o_data,
  input  logic [1:0]  o_rdy,
  output logic        busy,
  output logic        err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  // Words still to be moved after the header, by packet type
  localparam logic [3:0] c_short_rem = 4'(SHORT_LEN - 1);
  localparam logic [3:0] c_long_rem  = 4'(LONG_LEN - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_rem;
  logic [3:0] w_rem_nxt;
  logic [3:0] w_grant_rem;
  logic       r_gnt;          // owner of the packet in flight: 0 = A, 1 = B
  logic       w_gnt_nxt;

  logic       w_a_elig;
  logic       w_b_elig;
  logic       w_a_orph;
  logic       w_b_orph;
  logic       w_pick_b;
  logic       w_sel_stb;
  logic       w_sel_sof;

  logic       w_a_ack;
  logic       w_b_ack;
  logic       w_fwd;
  logic       w_fwd_b;
  logic       w_fwd_sof;
  logic       w_err;

`ifndef RBUS_ARB2_FIXED_PRIO_EN
  logic       r_last_b;       // last granted source: 0 = A, 1 = B
  logic       w_last_b_nxt;
`endif

  // A header is eligible only if downstream has room for its whole length
  assign w_a_elig = a_stb & a_sof & (a_data[LEN_BIT] ? o_rdy[1] : o_rdy[0]);
  assign w_b_elig = b_stb & b_sof & (b_data[LEN_BIT] ? o_rdy[1] : o_rdy[0]);

  // A non-header word seen outside a packet is an orphan
  assign w_a_orph = a_stb & ~a_sof;
  assign w_b_orph = b_stb & ~b_sof;

  // Choose B only when A cannot be chosen (or when it is B's turn)
`ifdef RBUS_ARB2_FIXED_PRIO_EN
  assign w_pick_b = w_b_elig & ~w_a_elig;
`else
  assign w_pick_b = w_b_elig & (~w_a_elig | ~r_last_b);
`endif

  assign w_grant_rem = (w_pick_b ? b_data[LEN_BIT] : a_data[LEN_BIT]) ? c_long_rem : c_short_rem;

  // Head word of the source that owns the current packet
  assign w_sel_stb = r_gnt ? b_stb : a_stb;
  assign w_sel_sof = r_gnt ? b_sof : a_sof;

  // Next-state, ack and forward decisions
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_gnt_nxt   = r_gnt;
    w_a_ack     = 1'b0;
    w_b_ack     = 1'b0;
    w_fwd       = 1'b0;
    w_fwd_b     = 1'b0;
    w_err       = 1'b0;
`ifndef RBUS_ARB2_FIXED_PRIO_EN
    w_last_b_nxt = r_last_b;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_a_orph) begin
          // Drop A's orphan first, no grant this cycle
          w_a_ack = 1'b1;
          w_err   = 1'b1;
        end else if (w_b_orph) begin
          w_b_ack = 1'b1;
          w_err   = 1'b1;
        end else if (w_a_elig | w_b_elig) begin
          w_fwd     = 1'b1;
          w_fwd_b   = w_pick_b;
          w_gnt_nxt = w_pick_b;
          w_a_ack   = ~w_pick_b;
          w_b_ack   = w_pick_b;
          w_rem_nxt = w_grant_rem;
`ifndef RBUS_ARB2_FIXED_PRIO_EN
          w_last_b_nxt = w_pick_b;
`endif
          if (w_grant_rem != 4'd0) begin
            w_state_nxt = ST_XFER;
          end
        end
      end
      ST_XFER: begin
        if (w_sel_stb & ~w_sel_sof) begin
          w_fwd     = 1'b1;
          w_fwd_b   = r_gnt;
          w_a_ack   = ~r_gnt;
          w_b_ack   = r_gnt;
          w_rem_nxt = r_rem - 4'd1;
          if (r_rem == 4'd1) begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_sel_stb & w_sel_sof) begin
          // Truncated packet: leave the new header for normal arbitration
          w_err       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_fwd_sof = w_fwd_b ? b_sof : a_sof;

  // Acks are combinational pops, so hold them off while reset is asserted
  assign a_ack = w_a_ack & rst;
  assign b_ack = w_b_ack & rst;
  assign busy  = (r_state == ST_XFER);

  // Arbiter state, owner and remaining-word counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_rem   <= 4'd0;
      r_gnt   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

`ifndef RBUS_ARB2_FIXED_PRIO_EN
  // Round-robin pointer starts at B so A wins the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_b <= 1'b1;
    end else begin
      r_last_b <= w_last_b_nxt;
    end
  end
`endif

  // Output register: each forwarded word appears one cycle after its ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_stb  <= 1'b0;
      o_sof  <= 1'b0;
      o_data <= 72'd0;
      err    <= 1'b0;
    end else begin
      o_stb <= w_fwd;
      o_sof <= w_fwd & w_fwd_sof;
      err   <= w_err;
      if (w_fwd) begin
        o_data <= w_fwd_b ? b_data : a_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rbus_arb2.sv
`default_nettype none
// ============================================================================
// Module   : tb_rbus_arb2
// Purpose  : Self-checking bench for rbus_arb2. Two FWFT sources are modelled
//            as word queues. A packet-level reference model predicts the acks,
//            the forwarded stream and the error pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rbus_arb2;

  localparam int SHORT = 2;
  localparam int LONG  = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_stb, a_sof, b_stb, b_sof;
  logic [71:0] a_data, b_data;
  logic        a_ack, b_ack;
  logic        o_stb, o_sof;
  logic [71:0] o_data;
  logic [1:0]  o_rdy;
  logic        busy, err;

  rbus_arb2 #(.SHORT_LEN(SHORT), .LONG_LEN(LONG), .LEN_BIT(71)) dut (
    .clk(clk), .rst(rst),
    .a_stb(a_stb), .a_sof(a_sof), .a_data(a_data), .a_ack(a_ack),
    .b_stb(b_stb), .b_sof(b_sof), .b_data(b_data), .b_ack(b_ack),
    .o_stb(o_stb), .o_sof(o_sof), .o_data(o_data), .o_rdy(o_rdy),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Source word queues, {sof, data}
  logic [72:0] aq[$];
  logic [72:0] bq[$];
  bit a_hold, b_hold;

  // Reference model: packet owner, words left, last granted (1 = B)
  bit m_busy;
  int m_own, m_left, m_last;
  logic        e_stb, e_sof, e_err;
  logic [71:0] e_data;

  // Observation log
  logic [72:0] out_q[$];
  int out_t[$];
  int cyc, n_aack, n_back, n_ostb, n_osof, n_err;

  task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] rnd72();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic push_word(input int src, input bit sof, input logic [71:0] d);
    if (src == 0) aq.push_back({sof, d});
    else          bq.push_back({sof, d});
  endtask

  // Push a packet: bit71 = length select, bit70 = source tag; n words total
  task automatic push_pkt(input int src, input bit is_long, input int n);
    logic [71:0] d;
    for (int i = 0; i < n; i++) begin
      d = rnd72();
      d[70] = (src != 0);
      if (i == 0) d[71] = is_long;
      push_word(src, (i == 0), d);
    end
  endtask

  task automatic drive();
    a_stb = (aq.size() > 0) && !a_hold;
    b_stb = (bq.size() > 0) && !b_hold;
    if (aq.size() > 0) {a_sof, a_data} = aq[0];
    else begin a_sof = 1'b0; a_data = rnd72(); end
    if (bq.size() > 0) {b_sof, b_data} = bq[0];
    else begin b_sof = 1'b0; b_data = rnd72(); end
  endtask

  task automatic clear_stats();
    out_q.delete(); out_t.delete();
    cyc = 0; n_aack = 0; n_back = 0; n_ostb = 0; n_osof = 0; n_err = 0;
  endtask

  // One clock cycle: check at negedge, commit model at posedge
  task automatic step();
    bit xa, xb, xf, xe, ea, eb, nb, s_stb, s_sof;
    logic [72:0] xw;
    int g, nl, no, nlast;
    @(negedge clk);
    chk("o_stb", o_stb, e_stb);
    chk("o_sof", o_sof, e_sof);
    chk("o_data", o_data, e_data);
    chk("err", err, e_err);
    chk("busy", busy, m_busy);
    xa = 0; xb = 0; xf = 0; xe = 0; xw = '0;
    nb = m_busy; nl = m_left; no = m_own; nlast = m_last;
    if (!m_busy) begin
      if (a_stb && !a_sof) begin xa = 1; xe = 1; end
      else if (b_stb && !b_sof) begin xb = 1; xe = 1; end
      else begin
        ea = a_stb && a_sof && (a_data[71] ? o_rdy[1] : o_rdy[0]);
        eb = b_stb && b_sof && (b_data[71] ? o_rdy[1] : o_rdy[0]);
        g = -1;
`ifdef RBUS_ARB2_FIXED_PRIO_EN
        if (ea && eb) g = 0;
`else
        if (ea && eb) g = (m_last == 0) ? 1 : 0;
`endif
        else if (ea) g = 0;
        else if (eb) g = 1;
        if (g >= 0) begin
          xf = 1; no = g; nlast = g;
          if (g == 0) begin xa = 1; xw = {1'b1, a_data}; end
          else        begin xb = 1; xw = {1'b1, b_data}; end
          nl = (xw[71] ? LONG : SHORT) - 1;
          nb = (nl > 0);
        end
      end
    end else begin
      s_stb = (m_own == 1) ? b_stb : a_stb;
      s_sof = (m_own == 1) ? b_sof : a_sof;
      if (s_stb && !s_sof) begin
        xf = 1;
        if (m_own == 1) begin xb = 1; xw = {1'b0, b_data}; end
        else            begin xa = 1; xw = {1'b0, a_data}; end
        nl = m_left - 1;
        if (nl == 0) nb = 0;
      end else if (s_stb && s_sof) begin
        xe = 1; nb = 0;
      end
    end
    chk("a_ack", a_ack, xa);
    chk("b_ack", b_ack, xb);
    if (o_stb) begin out_q.push_back({o_sof, o_data}); out_t.push_back(cyc); end
    n_aack += int'(a_ack); n_back += int'(b_ack);
    n_ostb += int'(o_stb); n_osof += int'(o_stb & o_sof); n_err += int'(err);
    @(posedge clk);
    if (xa) void'(aq.pop_front());
    if (xb) void'(bq.pop_front());
    e_stb = xf; e_sof = xf & xw[72]; e_err = xe;
    if (xf) e_data = xw[71:0];
    m_busy = nb; m_left = nl; m_own = no; m_last = nlast;
    cyc++;
    #1 drive();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    aq.delete(); bq.delete();
    a_hold = 0; b_hold = 0; o_rdy = 2'b11;
    // Orphan-looking words while in reset must not be acked
    a_stb = 1'b1; a_sof = 1'b0; a_data = rnd72();
    b_stb = 1'b1; b_sof = 1'b0; b_data = rnd72();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_stb", o_stb, 1'b0);
    chk("rst_o_sof", o_sof, 1'b0);
    chk("rst_o_data", o_data, 72'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_a_ack", a_ack, 1'b0);
    chk("rst_b_ack", b_ack, 1'b0);
    m_busy = 0; m_own = 0; m_left = 0; m_last = 1;
    e_stb = 0; e_sof = 0; e_err = 0; e_data = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    drive();
    clear_stats();
  endtask

  initial begin
    // Single long packet from A right after reset
    do_reset();
    push_pkt(0, 1'b1, LONG);
    drive();
    repeat (12) step();
    chk("t1_a_acks", n_aack, 9);
    chk("t1_o_stb_cycles", n_ostb, 9);
    chk("t1_o_sof_count", n_osof, 1);
    chk("t1_b_acks", n_back, 0);
    chk("t1_span", out_t[8] - out_t[0], 8);

    // Round-robin between short packets
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_pkt(0, 1'b0, SHORT);
      push_pkt(1, 1'b0, SHORT);
    end
    drive();
    repeat (20) step();
    chk("t2_words", n_ostb, 16);
    for (int i = 0; i < 8; i++) begin
`ifdef RBUS_ARB2_FIXED_PRIO_EN
      chk("t2_hdr_src", out_q[2*i][70], (i < 4) ? 1'b0 : 1'b1);
`else
      chk("t2_hdr_src", out_q[2*i][70], i[0]);
`endif
      chk("t2_hdr_sof", out_q[2*i][72], 1'b1);
      chk("t2_body_src", out_q[2*i+1][70], out_q[2*i][70]);
    end

    // Credit gating: only short room, long A waits
    do_reset();
    o_rdy = 2'b01;
    push_pkt(0, 1'b1, LONG);
    push_pkt(1, 1'b0, SHORT);
    drive();
    repeat (6) step();
    chk("t3_a_held", n_aack, 0);
    chk("t3_b_words", n_ostb, 2);
    chk("t3_b_hdr", out_q[0][70], 1'b1);
    o_rdy = 2'b11;
    clear_stats();
    drive();
    repeat (12) step();
    chk("t3_a_acks", n_aack, 9);
    chk("t3_a_hdr", out_q[0][70], 1'b0);
    chk("t3_a_first", out_t[0], 1);

    // Mid-packet stall from A, B must wait
    do_reset();
    push_pkt(0, 1'b1, LONG);
    push_pkt(1, 1'b0, SHORT);
    for (int i = 0; i < 16; i++) begin
      a_hold = (i >= 3 && i < 6);
      drive();
      step();
    end
    a_hold = 0;
    chk("t4_a_acks", n_aack, 9);
    chk("t4_stall_span", out_t[8] - out_t[0], 11);
    chk("t4_b_after", out_q[9][72:70], 3'b101);
    chk("t4_total", n_ostb, 11);

    // Truncated packet: new header after 3 words
    do_reset();
    push_pkt(0, 1'b1, 3);
    push_pkt(0, 1'b0, SHORT);
    drive();
    repeat (10) step();
    chk("t5_err_pulses", n_err, 1);
    chk("t5_words", n_ostb, 5);
    chk("t5_new_hdr", out_q[3][72], 1'b1);

    // Orphan word in IDLE is dropped
    do_reset();
    push_word(0, 1'b0, rnd72());
    push_pkt(0, 1'b0, SHORT);
    drive();
    repeat (6) step();
    chk("t5o_err_pulses", n_err, 1);
    chk("t5o_acks", n_aack, 3);
    chk("t5o_words", n_ostb, 2);
    chk("t5o_first_sof", out_q[0][72], 1'b1);

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      for (int s = 0; s < 2; s++) begin
        if (((s == 0) ? aq.size() : bq.size()) < 4 && $urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 24) == 0) push_word(s, 1'b0, rnd72());
          else if ($urandom_range(0, 9) == 0) push_pkt(s, 1'b1, $urandom_range(1, LONG - 1));
          else begin
            if ($urandom_range(0, 1) == 1) push_pkt(s, 1'b1, LONG);
            else push_pkt(s, 1'b0, SHORT);
          end
        end
      end
      a_hold = ($urandom_range(0, 3) == 0);
      b_hold = ($urandom_range(0, 3) == 0);
      o_rdy = 2'($urandom_range(0, 3));
      drive();
      step();
    end
    a_hold = 0; b_hold = 0;

    // Asynchronous reset in the middle of a packet
    do_reset();
    push_pkt(0, 1'b1, LONG);
    push_pkt(1, 1'b0, SHORT);
    drive();
    repeat (4) step();
    #2 rst = 1'b0;
    #1;
    chk("t7_busy_clr", busy, 1'b0);
    chk("t7_o_stb_clr", o_stb, 1'b0);
    chk("t7_o_data_clr", o_data, 72'd0);
    chk("t7_err_clr", err, 1'b0);
    chk("t7_a_ack_clr", a_ack, 1'b0);
    do_reset();
    push_pkt(1, 1'b0, SHORT);
    push_pkt(0, 1'b0, SHORT);
    drive();
    repeat (6) step();
    chk("t7_first_grant_a", out_q[0][72:70], 3'b100);
    chk("t7_words", n_ostb, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
